alarm_ctrl: RTL
===============

# alarm_ctrl

- Sequential stage directly downstream of the combinational alarm-condition logic; consumes its single output `L` (alarm condition).
- Synchronises and debounces `L`, latches a qualified alarm, drives a siren and a blinking lamp, and supports operator acknowledge and automatic siren timeout.
- Counts qualified alarm events for status readout.

## Interface

Parameters:
- `DEBOUNCE`, 4: consecutive synchronised-high samples of `L` required to raise an alarm (≥1).
- `BLINK_HALF`, 8: lamp half-period in clock cycles while the siren sounds (≥1).
- `TIMEOUT`, 64: maximum siren-on duration in clock cycles without acknowledge (≥1).

Ports:
- `clk`, input, 1: system clock. One clock; all state is rising-edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `L`, input, 1: raw alarm condition from the upstream combinational stage. Asynchronous to `clk`.
- `ack`, input, 1: operator acknowledge. Synchronous to `clk`; level-sampled.
- `siren`, output, 1: siren drive, registered.
- `lamp`, output, 1: lamp drive, registered.
- `alarm_active`, output, 1: high in ALARM or SILENCED, registered.
- `event_count`, output, 8: number of entries into ALARM; saturates at 255.

## Operation

- **Synchroniser:** two-flop chain on `L`; its output is `l_s`. Both flops reset to 0.

**States:** IDLE, QUAL, ALARM, SILENCED.
- **IDLE:**
  - `l_s`=1 → QUAL, qualify count = 1.
  - `ack` is ignored.
- **QUAL:**
  - `l_s`=0 → IDLE; qualify count is cleared.
  - Otherwise the count increments. When the count reaches `DEBOUNCE`, the state goes to ALARM on that same edge.
  - With `DEBOUNCE`=1, IDLE goes straight to ALARM.
  - `ack` is ignored.
- **ALARM:**
  - Outputs: `siren`=1, `alarm_active`=1.
  - `lamp` is 1 on entry and toggles every `BLINK_HALF` cycles.
  - On entry, the blink counter and timeout counter clear, and `event_count` increments (held at 255 once reached).
  - Alarm is latching: `l_s` returning to 0 does not leave ALARM.
  - `ack`=1 → SILENCED.
  - Timeout counter reaching `TIMEOUT` → SILENCED.
  - `ack` and timeout in the same cycle → SILENCED (identical result).
- **SILENCED:**
  - Outputs: `siren`=0, `lamp`=1 steady, `alarm_active`=1.
  - `l_s`=0 → IDLE.
  - `l_s`=1 → stay; no re-alarm until `L` has dropped and re-qualified through IDLE/QUAL.
  - `ack` is ignored.
- **IDLE/QUAL outputs:** `siren`=0, `lamp`=0, `alarm_active`=0.
- **Reset (including mid-operation):**
  - Immediately forces IDLE.
  - All outputs, counters and synchroniser flops go to 0.
  - `event_count` clears.
  - The first rising edge after deassertion behaves as from IDLE.

## Timing

- All outputs are registered, with no combinational path from input to output.
- **Alarm latency:** `L` sampled high at edge 1 and held gives `siren`/`alarm_active`/`lamp` = 1 after edge `DEBOUNCE`+2 (6 with defaults). `event_count` updates on the same edge.
- **Debounce rejection:** any `l_s` low sample during QUAL restarts qualification. A raw `L` pulse covering fewer than `DEBOUNCE` consecutive sampling edges never alarms.
- **Siren duration:** `siren` is high for exactly `TIMEOUT` cycles if not acknowledged.
- **Acknowledge:** `ack` sampled high at edge e in ALARM → `siren`=0 and `lamp`=1 after edge e.
- **Lamp blink:** in ALARM, `lamp` holds each level for exactly `BLINK_HALF` cycles.
- **Release:** `L` sampled low at edge r while SILENCED → IDLE (all outputs 0) after edge r+2.

## Test plan

1. **Reset:** hold `rst_n`=0 with `L`=1 and `ack`=1 → `siren`=0, `lamp`=0, `alarm_active`=0, `event_count`=0 throughout. Release reset with `L`=1 → `siren` rises 6 edges later.
2. **Glitch rejection:** pulse `L` high for 3 cycles, then low for 20 cycles → `siren` never rises; `event_count` stays 0.
3. **Qualified alarm:** hold `L`=1 from edge 1 → `siren`=1, `lamp`=1, `event_count`=1 after edge 6. `lamp` goes low at +8 cycles and high at +16.
4. **Ack and release:** one-cycle `ack` at cycle 10 of ALARM → `siren`=0 and `lamp`=1 steady next edge. Drop `L` → IDLE 2 edges later. Re-raise `L` → `event_count`=2.
5. **Timeout and latch:** raise `L` until alarm, drop `L`, no `ack` → `siren` high exactly 64 cycles, then SILENCED. IDLE follows on the next edge because `l_s`=0.
6. **Async reset mid-alarm:** assert `rst_n`=0 between edges during ALARM → all outputs 0 before the next edge. Separately, with `DEBOUNCE`=1, run 256 alarm cycles → `event_count` holds at 255.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Debounced, latching alarm controller: sync + qualify L, drive siren/blinking lamp, count alarm events.
// Latency: L to siren after DEBOUNCE+2 edges, ack to siren off in 1 edge; no backpressure (level inputs, registered outputs).
module alarm_ctrl #(
    parameter int DEBOUNCE   = 4,
    parameter int BLINK_HALF = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       L,
    input  logic       ack,
    output logic       siren,
    output logic       lamp,
    output logic       alarm_active,
    output logic [7:0] event_count
);
    localparam int QW = (DEBOUNCE   > 1) ? $clog2(DEBOUNCE)   : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;
    localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, QUAL, ALARM, SILENCED} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [QW-1:0] qual_q, qual_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    evt_q, evt_d;
    logic          siren_q, siren_d;
    logic          lamp_q, lamp_d;
    logic          active_q, active_d;
    logic          l_s;
    logic          enter_alarm;
    logic          blink_wrap;

    assign l_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            qual_q   <= '0;
            blink_q  <= '0;
            tmo_q    <= '0;
            evt_q    <= '0;
            siren_q  <= 1'b0;
            lamp_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= L;
            sync2_q  <= sync1_q;
            qual_q   <= qual_d;
            blink_q  <= blink_d;
            tmo_q    <= tmo_d;
            evt_q    <= evt_d;
            siren_q  <= siren_d;
            lamp_q   <= lamp_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        qual_d      = qual_q;
        blink_d     = blink_q;
        tmo_d       = tmo_q;
        evt_d       = evt_q;
        enter_alarm = 1'b0;
        blink_wrap  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (l_s) begin
                    if (DEBOUNCE == 1) begin
                        enter_alarm = 1'b1;
                    end else begin
                        state_d = QUAL;
                        qual_d  = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!l_s) begin
                    state_d = IDLE;
                    qual_d  = '0;
                end else if (qual_q == QMAX) begin
                    enter_alarm = 1'b1;
                end else begin
                    qual_d = qual_q + QW'(1);
                end
            end
            ALARM: begin
                // Latching: l_s is deliberately not examined here.
                if (ack || (tmo_q == TMAX)) begin
                    state_d = SILENCED;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (blink_q == BMAX) begin
                    blink_wrap = 1'b1;
                    blink_d    = '0;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            SILENCED: begin
                if (!l_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_alarm) begin
            state_d = ALARM;
            qual_d  = '0;
            blink_d = '0;
            tmo_d   = '0;
            if (evt_q != 8'hFF) begin
                evt_d = evt_q + 8'd1;
            end
        end

        siren_d  = (state_d == ALARM);
        active_d = (state_d == ALARM) || (state_d == SILENCED);
        unique case (state_d)
            ALARM:    lamp_d = enter_alarm ? 1'b1 : (blink_wrap ? ~lamp_q : lamp_q);
            SILENCED: lamp_d = 1'b1;
            default:  lamp_d = 1'b0;
        endcase
    end

    assign siren        = siren_q;
    assign lamp         = lamp_q;
    assign alarm_active = active_q;
    assign event_count  = evt_q;
endmodule
